// File: rtl/mem_read_arbiter_pkg.sv
// Shared definitions for the memory read-port arbiter.
package mem_read_arbiter_pkg;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

endpackage

// File: rtl/mem_read_arbiter_rr_picker.sv
// Rotating-priority encoder: picks the first set request at or after ptr,
// wrapping modulo NUM_REQ (NUM_REQ need not be a power of two).
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int ID_WDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_WDTH-1:0] i_ptr,
    output logic               o_any,
    output logic [ID_WDTH-1:0] o_idx
);

    int w_best;
    int w_dist;

    // Choose the set request with the smallest rotational distance from ptr
    always_comb begin
        o_any  = 1'b0;
        o_idx  = '0;
        w_best = NUM_REQ;
        w_dist = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_dist = (k >= int'(i_ptr)) ? (k - int'(i_ptr)) : (k + NUM_REQ - int'(i_ptr));
            if (i_req[k] && (w_dist < w_best)) begin
                w_best = w_dist;
                o_idx  = ID_WDTH'(k);
                o_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one memory AR/R read port between NUM_REQ
// requesters, with a single outstanding transaction at a time.
//
//  state   | meaning
//  --------+---------------------------------------------------------
//  IDLE    | no grant held, waiting for any req_ar_valid
//  ADDR    | grant held, forwarding the winner's AR to memory
//  DATA    | address accepted, routing the R beat back to the winner
module mem_read_arbiter
    import mem_read_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_WDTH = 4,
    parameter int DATA_WDTH = 32,
    parameter int RESP_WDTH = 1,
    localparam int ID_WDTH  = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_ar_valid,
    output logic [NUM_REQ-1:0]             req_ar_ready,
    input  logic [NUM_REQ*ADDR_WDTH-1:0]   req_ar_address,
    output logic [NUM_REQ-1:0]             req_r_valid,
    input  logic [NUM_REQ-1:0]             req_r_ready,
    output logic [DATA_WDTH-1:0]           req_r_data,
    output logic [RESP_WDTH-1:0]           req_r_resp,
    output logic                           ar_valid,
    input  logic                           ar_ready,
    output logic [ADDR_WDTH-1:0]           ar_address,
    input  logic                           r_valid,
    output logic                           r_ready,
    input  logic [DATA_WDTH-1:0]           r_data,
    input  logic [RESP_WDTH-1:0]           r_resp,
    output logic                           busy,
    output logic [ID_WDTH-1:0]             grant_id
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ID_WDTH-1:0]   r_rr_ptr;
    logic [ID_WDTH-1:0]   w_rr_ptr_nxt;
    logic [ID_WDTH-1:0]   r_grant_id;
    logic [ID_WDTH-1:0]   w_grant_nxt;
    logic [ID_WDTH-1:0]   w_pick_idx;
    logic                 w_pick_any;
    logic [NUM_REQ-1:0]   w_grant_oh;
    logic                 w_sel_ar_valid;
    logic [ADDR_WDTH-1:0] w_sel_addr;
    logic                 w_sel_r_ready;
    logic                 w_r_done;

    // Route the granted requester's AR/R-ready signals onto shared wires
    always_comb begin
        w_grant_oh     = '0;
        w_sel_ar_valid = 1'b0;
        w_sel_addr     = '0;
        w_sel_r_ready  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r_grant_id == ID_WDTH'(k)) begin
                w_grant_oh[k]  = 1'b1;
                w_sel_ar_valid = req_ar_valid[k];
                w_sel_addr     = req_ar_address[k*ADDR_WDTH +: ADDR_WDTH];
                w_sel_r_ready  = req_r_ready[k];
            end
        end
    end

    assign ar_valid     = (r_state == ST_ADDR) && w_sel_ar_valid;
    assign ar_address   = w_sel_addr;
    assign req_ar_ready = ((r_state == ST_ADDR) && ar_ready) ? w_grant_oh : '0;
    assign req_r_valid  = ((r_state == ST_DATA) && r_valid) ? w_grant_oh : '0;
    assign r_ready      = (r_state == ST_DATA) && w_sel_r_ready;
    assign req_r_data   = r_data;
    assign req_r_resp   = r_resp;
    assign busy         = (r_state != ST_IDLE);
    assign grant_id     = r_grant_id;

    assign w_r_done = (r_state == ST_DATA) && r_valid && r_ready;

    // The picker sees the post-completion pointer so back-to-back grants
    // already honour the just-finished requester's demotion.
    assign w_rr_ptr_nxt = !w_r_done ? r_rr_ptr :
                          (r_grant_id == ID_WDTH'(NUM_REQ - 1)) ? '0 : (r_grant_id + 1'b1);

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_WDTH (ID_WDTH)
    ) u_picker (
        .i_req (req_ar_valid),
        .i_ptr (w_rr_ptr_nxt),
        .o_any (w_pick_any),
        .o_idx (w_pick_idx)
    );

    // Next-state and next-grant decision
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant_id;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = ST_ADDR;
                    w_grant_nxt = w_pick_idx;
                end
            end
            ST_ADDR: begin
                if (ar_valid && ar_ready) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_r_done) begin
                    if (w_pick_any) begin
                        w_state_nxt = ST_ADDR;
                        w_grant_nxt = w_pick_idx;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, grant and round-robin pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_grant_id <= w_grant_nxt;
        end
    end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter: a 2-requester and a 3-requester instance.
module tb_mem_read_arbiter;

    logic clk;
    logic rst_n;

    // NUM_REQ = 2 instance
    logic [1:0]  a_vld, a_ardy, a_rvld, a_rrdy;
    logic [7:0]  a_addr;
    logic [31:0] a_rdat;
    logic [0:0]  a_rrsp;
    logic        a_mem_arv, a_mem_arr, a_mem_rv, a_mem_rr, a_busy;
    logic [3:0]  a_mem_addr;
    logic [31:0] a_mem_rdat;
    logic [0:0]  a_mem_rrsp;
    logic [0:0]  a_gid;

    // NUM_REQ = 3 instance
    logic [2:0]  b_vld, b_ardy, b_rvld, b_rrdy;
    logic [11:0] b_addr;
    logic [31:0] b_rdat;
    logic [0:0]  b_rrsp;
    logic        b_mem_arv, b_mem_arr, b_mem_rv, b_mem_rr, b_busy;
    logic [3:0]  b_mem_addr;
    logic [31:0] b_mem_rdat;
    logic [0:0]  b_mem_rrsp;
    logic [1:0]  b_gid;

    int n_tests = 0;
    int n_fail  = 0;

    mem_read_arbiter #(.NUM_REQ(2), .ADDR_WDTH(4), .DATA_WDTH(32), .RESP_WDTH(1)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_ar_valid(a_vld), .req_ar_ready(a_ardy), .req_ar_address(a_addr),
        .req_r_valid(a_rvld), .req_r_ready(a_rrdy), .req_r_data(a_rdat), .req_r_resp(a_rrsp),
        .ar_valid(a_mem_arv), .ar_ready(a_mem_arr), .ar_address(a_mem_addr),
        .r_valid(a_mem_rv), .r_ready(a_mem_rr), .r_data(a_mem_rdat), .r_resp(a_mem_rrsp),
        .busy(a_busy), .grant_id(a_gid)
    );

    mem_read_arbiter #(.NUM_REQ(3), .ADDR_WDTH(4), .DATA_WDTH(32), .RESP_WDTH(1)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_ar_valid(b_vld), .req_ar_ready(b_ardy), .req_ar_address(b_addr),
        .req_r_valid(b_rvld), .req_r_ready(b_rrdy), .req_r_data(b_rdat), .req_r_resp(b_rrsp),
        .ar_valid(b_mem_arv), .ar_ready(b_mem_arr), .ar_address(b_mem_addr),
        .r_valid(b_mem_rv), .r_ready(b_mem_rr), .r_data(b_mem_rdat), .r_resp(b_mem_rrsp),
        .busy(b_busy), .grant_id(b_gid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_vld = '0; a_addr = '0; a_rrdy = '0; a_mem_arr = 1'b0; a_mem_rv = 1'b0;
        a_mem_rdat = '0; a_mem_rrsp = '0;
        b_vld = '0; b_addr = '0; b_rrdy = '0; b_mem_arr = 1'b0; b_mem_rv = 1'b0;
        b_mem_rdat = '0; b_mem_rrsp = '0;
        #3;
        chk("rst_busy", a_busy, 0);
        chk("rst_gid", a_gid, 0);
        chk("rst_arv", a_mem_arv, 0);
        chk("rst_b_busy", b_busy, 0);
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a DATA phase
        a_vld = 2'b01; a_addr = {4'h9, 4'h3}; a_mem_arr = 1'b1;
        tick();
        chk("t1_addr_busy", a_busy, 1);
        chk("t1_addr_arv", a_mem_arv, 1);
        chk("t1_addr_gid", a_gid, 0);
        tick();
        a_vld = 2'b00; a_mem_rv = 1'b1; a_rrdy = 2'b01;
        #1;
        chk("t1_data_rvld", a_rvld, 2'b01);
        chk("t1_data_rrdy", a_mem_rr, 1);
        rst_n = 1'b0;
        #1;
        chk("t1_async_busy", a_busy, 0);
        chk("t1_async_rvld", a_rvld, 0);
        chk("t1_async_rrdy", a_mem_rr, 0);
        chk("t1_async_arv", a_mem_arv, 0);
        chk("t1_async_ardy", a_ardy, 0);
        chk("t1_async_gid", a_gid, 0);
        a_mem_rv = 1'b0; a_rrdy = 2'b00;
        rst_n = 1'b1;
        tick();
        chk("t1_post_idle", a_busy, 0);

        // Both requesters held valid: strict alternation starting at 0, no idle gaps
        a_vld = 2'b11; a_mem_arr = 1'b1; a_mem_rv = 1'b1; a_rrdy = 2'b11;
        a_mem_rdat = 32'h1234_5678;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t3_gid", a_gid, i % 2);
            chk("t3_addr", a_mem_addr, (i % 2 == 0) ? 4'h3 : 4'h9);
            chk("t3_busy_a", a_busy, 1);
            chk("t3_arv", a_mem_arv, 1);
            tick();
            chk("t3_busy_d", a_busy, 1);
            chk("t3_rvld", a_rvld, (i % 2 == 0) ? 2'b01 : 2'b10);
            chk("t3_rdat", a_rdat, 32'h1234_5678);
            if (i == 3) a_vld = 2'b00;
            tick();
        end
        chk("t3_end_idle", a_busy, 0);

        // Single requester 1, address 7, data two cycles after the address
        a_mem_rv = 1'b0; a_rrdy = 2'b00; a_vld = 2'b10; a_addr = {4'h7, 4'h3};
        #1;
        chk("t2_no_comb_arv", a_mem_arv, 0);
        tick();
        chk("t2_arv", a_mem_arv, 1);
        chk("t2_addr", a_mem_addr, 4'h7);
        chk("t2_gid", a_gid, 1);
        chk("t2_ardy", a_ardy, 2'b10);
        tick();
        a_vld = 2'b00;
        #1;
        chk("t2_d1_ardy", a_ardy, 2'b00);
        chk("t2_d1_rvld", a_rvld, 2'b00);
        tick();
        a_mem_rv = 1'b1; a_mem_rdat = 32'hDEAD_BEEF; a_rrdy = 2'b10;
        #1;
        chk("t2_rvld", a_rvld, 2'b10);
        chk("t2_rdat", a_rdat, 32'hDEAD_BEEF);
        chk("t2_rrdy", a_mem_rr, 1);
        tick();
        chk("t2_idle", a_busy, 0);

        // Unsolicited r_valid while stalled in ADDR
        a_vld = 2'b01; a_mem_arr = 1'b0; a_mem_rv = 1'b1; a_rrdy = 2'b11;
        tick();
        chk("t5_rrdy", a_mem_rr, 0);
        chk("t5_rvld", a_rvld, 2'b00);
        chk("t5_ardy", a_ardy, 2'b00);
        chk("t5_arv", a_mem_arv, 1);
        tick();
        chk("t5_stay_addr", a_mem_arv, 1);
        chk("t5_gid", a_gid, 0);

        // Requester back-pressure on R for three cycles
        a_mem_arr = 1'b1; a_mem_rv = 1'b0; a_rrdy = 2'b00;
        #1;
        chk("t6_ardy", a_ardy, 2'b01);
        tick();
        a_vld = 2'b11; a_mem_rv = 1'b1; a_rrdy = 2'b00;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t6_stall_rrdy", a_mem_rr, 0);
            chk("t6_stall_rvld", a_rvld, 2'b01);
            chk("t6_stall_arv", a_mem_arv, 0);
            tick();
        end
        a_rrdy = 2'b01;
        #1;
        chk("t6_rrdy", a_mem_rr, 1);
        tick();
        chk("t6_next_gid", a_gid, 1);
        chk("t6_next_arv", a_mem_arv, 1);
        a_vld = 2'b10;
        tick();
        a_vld = 2'b00; a_rrdy = 2'b10;
        tick();
        chk("t6_idle", a_busy, 0);
        a_mem_rv = 1'b0; a_rrdy = 2'b00;

        // Three requesters: bring rr_ptr to 2, then all valid -> 2,0,1
        b_vld = 3'b010; b_addr = {4'hC, 4'hB, 4'hA}; b_mem_arr = 1'b1;
        b_mem_rv = 1'b1; b_rrdy = 3'b111;
        tick();
        chk("t4_first_gid", b_gid, 1);
        chk("t4_first_addr", b_mem_addr, 4'hB);
        tick();
        b_vld = 3'b111;
        tick();
        chk("t4_gid_2", b_gid, 2);
        chk("t4_addr_2", b_mem_addr, 4'hC);
        tick();
        tick();
        chk("t4_gid_0", b_gid, 0);
        chk("t4_addr_0", b_mem_addr, 4'hA);
        tick();
        tick();
        chk("t4_gid_1", b_gid, 1);
        chk("t4_busy", b_busy, 1);
        tick();
        b_vld = 3'b000;
        tick();
        chk("t4_idle", b_busy, 0);
        chk("t4_gid_hold", b_gid, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
